// File: rtl/stepper_pkg.sv
// Shared types for the bipolar stepper driver: step modes, coil drive states
// and the eight-entry (A,B) phase table walked by the sequencer.
package stepper_pkg;

    typedef enum logic [1:0] {
        WAVE     = 2'd0,
        FULL     = 2'd1,
        HALF     = 2'd2,
        HALF_ALT = 2'd3
    } step_mode_t;

    typedef enum logic [1:0] {
        COIL_OFF = 2'd0,
        COIL_POS = 2'd1,
        COIL_NEG = 2'd2
    } coil_t;

    typedef struct packed {
        coil_t a;
        coil_t b;
    } phase_t;

    // Even entries energise one coil, odd entries energise both.
    localparam phase_t PHASE_TABLE [8] = '{
        '{COIL_POS, COIL_OFF},
        '{COIL_POS, COIL_POS},
        '{COIL_OFF, COIL_POS},
        '{COIL_NEG, COIL_POS},
        '{COIL_NEG, COIL_OFF},
        '{COIL_NEG, COIL_NEG},
        '{COIL_OFF, COIL_NEG},
        '{COIL_POS, COIL_NEG}
    };

    // Returns {IN1, IN2}; coast leaves both bridge legs low.
    function automatic logic [1:0] coil_to_in(input coil_t c);
        case (c)
            COIL_POS: return 2'b10;
            COIL_NEG: return 2'b01;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/stepper_driver_ms_if.sv
// Control and bridge-side signal bundle between the motion controller and
// the stepper driver.
interface stepper_driver_ms_if #(
    parameter int PWM_BITS = 4,
    parameter int POS_BITS = 16
);
    logic                module_enable;
    logic                step_pulse;
    logic                direction;
    logic [1:0]          step_mode;
    logic [PWM_BITS-1:0] vref_run;
    logic [PWM_BITS-1:0] vref_hold;
    logic                pos_clr;

    logic                INA1;
    logic                INA2;
    logic                INB1;
    logic                INB2;
    logic                STANBY;
    logic                VREF_PWM;
    logic [2:0]          phase_idx;
    logic [POS_BITS-1:0] position;
    logic                step_ack;
    logic                idle;

    modport master (
        output module_enable, step_pulse, direction, step_mode,
               vref_run, vref_hold, pos_clr,
        input  INA1, INA2, INB1, INB2, STANBY, VREF_PWM,
               phase_idx, position, step_ack, idle
    );

    modport slave (
        input  module_enable, step_pulse, direction, step_mode,
               vref_run, vref_hold, pos_clr,
        output INA1, INA2, INB1, INB2, STANBY, VREF_PWM,
               phase_idx, position, step_ack, idle
    );

endinterface

// File: rtl/vref_pwm.sv
// Free-running current-limit PWM: output is high while the counter is below
// the requested level, so level 0 is off and full scale is (2^N-1)/2^N.
module vref_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] level,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] cnt_reg;
    logic [PWM_BITS-1:0] cnt_next;
    logic                pwm_reg;
    logic                pwm_next;

    always_comb begin
        cnt_next = cnt_reg + PWM_BITS'(1);
        pwm_next = en && (cnt_reg < level);
    end

    // Level is compared every cycle, so a new level applies without
    // restarting the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            pwm_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            pwm_reg <= pwm_next;
        end
    end

    assign pwm_out = pwm_reg;

endmodule

// File: rtl/stepper_driver_ms.sv
// Two-phase bipolar stepper sequencer: synchronises step pulses, walks the
// shared phase table in wave/full/half mode and drives the dual H-bridge.
module stepper_driver_ms
    import stepper_pkg::*;
#(
    parameter int PWM_BITS    = 4,
    parameter int IDLE_CYCLES = 2700000,
    parameter int POS_BITS    = 16
) (
    input  logic           clk,
    input  logic           rst,
    stepper_driver_ms_if.slave bus
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    logic [2:0]          sync_reg;
    logic                step_edge;
    logic                step_accept;
    step_mode_t          mode;
    logic [2:0]          idx_inc;
    logic [2:0]          idx_reg;
    logic [2:0]          idx_next;
    logic [POS_BITS-1:0] pos_reg;
    logic [POS_BITS-1:0] pos_next;
    logic [IDLE_W-1:0]   idle_cnt_reg;
    logic [IDLE_W-1:0]   idle_cnt_next;
    logic                idle_flag;
    phase_t              phase;
    logic [1:0]          coil_in [2];
    logic [3:0]          coil_reg;
    logic [3:0]          coil_next;
    logic                stanby_reg;
    logic                ack_reg;
    logic [PWM_BITS-1:0] pwm_level;
    logic                vref_pwm_out;

    // sync_reg[1:0] is the two-flop synchroniser, sync_reg[2] the edge history.
    assign step_edge   = sync_reg[1] & ~sync_reg[2];
    assign step_accept = step_edge & bus.module_enable;
    assign idle_flag   = (idle_cnt_reg == IDLE_MAX);

    // Wave wants even indices and full wants odd ones; a parity mismatch
    // (e.g. after a mode change) is corrected by a single half step.
    always_comb begin
        mode = step_mode_t'(bus.step_mode);
        case (mode)
            WAVE:    idx_inc = idx_reg[0] ? 3'd1 : 3'd2;
            FULL:    idx_inc = idx_reg[0] ? 3'd2 : 3'd1;
            default: idx_inc = 3'd1;
        endcase
    end

    always_comb begin
        idx_next      = idx_reg;
        pos_next      = pos_reg;
        idle_cnt_next = idle_cnt_reg;
        if (step_accept) begin
            idx_next      = bus.direction ? idx_reg + idx_inc : idx_reg - idx_inc;
            pos_next      = bus.direction ? pos_reg + POS_BITS'(1)
                                          : pos_reg - POS_BITS'(1);
            idle_cnt_next = '0;
        end else if (bus.module_enable && (idle_cnt_reg != IDLE_MAX)) begin
            idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
        if (bus.pos_clr) begin
            pos_next = '0;
        end
    end

    // Coil outputs are decoded from the next index so they land together
    // with the index update and step_ack.
    assign phase = PHASE_TABLE[idx_next];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_coil
            assign coil_in[gi] = coil_to_in((gi == 0) ? phase.a : phase.b);
        end
    endgenerate

    always_comb begin
        coil_next = 4'b0000;
        if (bus.module_enable) begin
            coil_next = {coil_in[0], coil_in[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg     <= '0;
            idx_reg      <= '0;
            pos_reg      <= '0;
            idle_cnt_reg <= '0;
            coil_reg     <= '0;
            stanby_reg   <= 1'b0;
            ack_reg      <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[1:0], bus.step_pulse};
            idx_reg      <= idx_next;
            pos_reg      <= pos_next;
            idle_cnt_reg <= idle_cnt_next;
            coil_reg     <= coil_next;
            stanby_reg   <= bus.module_enable;
            ack_reg      <= step_accept;
        end
    end

    assign pwm_level = idle_flag ? bus.vref_hold : bus.vref_run;

    vref_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_vref_pwm (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.module_enable),
        .level   (pwm_level),
        .pwm_out (vref_pwm_out)
    );

    assign bus.INA1      = coil_reg[3];
    assign bus.INA2      = coil_reg[2];
    assign bus.INB1      = coil_reg[1];
    assign bus.INB2      = coil_reg[0];
    assign bus.STANBY    = stanby_reg;
    assign bus.VREF_PWM  = vref_pwm_out;
    assign bus.phase_idx = idx_reg;
    assign bus.position  = pos_reg;
    assign bus.step_ack  = ack_reg;
    assign bus.idle      = idle_flag;

endmodule

// File: tb/tb_stepper_driver_ms.sv
// Scoreboard bench for stepper_driver_ms: each driven step pushes its expected
// index/coils/position/ack cycle, popped when the DUT raises step_ack.
module tb_stepper_driver_ms;
    import stepper_pkg::*;

    localparam int PWM_BITS    = 4;
    localparam int IDLE_CYCLES = 20;
    localparam int POS_BITS    = 4;

    // {INA1,INA2,INB1,INB2} for each table index
    localparam logic [3:0] COIL_TBL [8] = '{
        4'b1000, 4'b1010, 4'b0010, 4'b0110,
        4'b0100, 4'b0101, 4'b0001, 4'b1001
    };

    typedef struct packed {
        logic [2:0]          idx;
        logic [3:0]          coils;
        logic [POS_BITS-1:0] pos;
        logic [31:0]         cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    int                  checks = 0;
    int                  failures = 0;
    logic [31:0]         cyc = 0;
    logic [31:0]         last_ack_cyc = 0;
    exp_t                sb_q [$];
    logic [2:0]          m_idx = 3'd0;
    logic [POS_BITS-1:0] m_pos = '0;

    stepper_driver_ms_if #(.PWM_BITS(PWM_BITS), .POS_BITS(POS_BITS)) bus ();

    stepper_driver_ms #(
        .PWM_BITS    (PWM_BITS),
        .IDLE_CYCLES (IDLE_CYCLES),
        .POS_BITS    (POS_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] coils_now();
        return {bus.INA1, bus.INA2, bus.INB1, bus.INB2};
    endfunction

    // One rising edge on step_pulse; pos_clr is raised on the edge-detect cycle.
    task automatic do_step(input logic clr);
        int inc;
        if (bus.module_enable) begin
            case (bus.step_mode)
                2'd0:    inc = m_idx[0] ? 1 : 2;
                2'd1:    inc = m_idx[0] ? 2 : 1;
                default: inc = 1;
            endcase
            m_idx = bus.direction ? m_idx + 3'(inc) : m_idx - 3'(inc);
            m_pos = clr ? '0 : (bus.direction ? m_pos + 1'b1 : m_pos - 1'b1);
            sb_q.push_back('{idx: m_idx, coils: COIL_TBL[m_idx], pos: m_pos, cyc: cyc + 3});
        end
        bus.step_pulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.pos_clr = clr;
        @(negedge clk);
        bus.pos_clr    = 1'b0;
        bus.step_pulse = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("step mode=%0d dir=%0d en=%0d clr=%0d -> idx=%0d pos=%0d coils=%b",
                 bus.step_mode, bus.direction, bus.module_enable, clr,
                 bus.phase_idx, bus.position, coils_now());
    endtask

    task automatic duty(input string tag, input int exp);
        int highs = 0;
        repeat (16) begin
            @(negedge clk);
            highs += int'(bus.VREF_PWM);
        end
        check(tag, highs, exp);
        $display("duty %s highs=%0d/16", tag, highs);
    endtask

    // Scoreboard consumer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.step_ack) begin
                last_ack_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_cycle", cyc, e.cyc);
                    check("phase_idx", bus.phase_idx, e.idx);
                    check("coils", coils_now(), e.coils);
                    check("position", bus.position, e.pos);
                    check("idle_at_ack", bus.idle, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.module_enable = 1'b1;
        bus.step_pulse    = 1'b0;
        bus.direction     = 1'b1;
        bus.step_mode     = HALF;
        bus.vref_run      = 4'd12;
        bus.vref_hold     = 4'd3;
        bus.pos_clr       = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_coils", coils_now(), 0);
        check("rst_stanby", bus.STANBY, 0);
        check("rst_vref", bus.VREF_PWM, 0);
        check("rst_idx", bus.phase_idx, 0);
        check("rst_pos", bus.position, 0);
        check("rst_ack", bus.step_ack, 0);
        check("rst_idle", bus.idle, 0);
        rst = 1'b0;
        @(negedge clk);
        check("en_coils_idx0", coils_now(), 4'b1000);

        // Half steps forward through a full revolution of the table
        repeat (8) do_step(1'b0);
        check("half_wrap_idx", bus.phase_idx, 0);
        check("pos_wrap", bus.position, 4'b1000);

        // pos_clr coinciding with accepted steps
        do_step(1'b1);
        bus.direction = 1'b0;
        do_step(1'b1);
        check("clr_pos", bus.position, 0);

        // Full mode backwards from idx 0: realign to 7, then 5, 3
        bus.step_mode = FULL;
        repeat (3) do_step(1'b0);
        check("full_idx", bus.phase_idx, 3);
        check("full_coils", coils_now(), 4'b0110);
        check("full_pos", bus.position, 4'b1101);

        // Wave mode forward from 3: realign to 4, then 6
        bus.step_mode = WAVE;
        bus.direction = 1'b1;
        repeat (2) do_step(1'b0);
        check("wave_idx", bus.phase_idx, 6);

        // Hold-current reduction after the idle timeout
        n = 0;
        while (!bus.idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_rise", bus.idle, 1);
        check("idle_delay", cyc - last_ack_cyc, IDLE_CYCLES);
        @(negedge clk);
        duty("duty_hold", 3);
        do_step(1'b0);
        check("idle_drop", bus.idle, 0);
        duty("duty_run", 12);

        // Move to idx 5, then disable and send ignored steps
        bus.step_mode = HALF;
        bus.direction = 1'b0;
        do_step(1'b0);
        bus.step_mode = FULL;
        do_step(1'b0);
        check("pre_dis_idx", bus.phase_idx, 5);
        bus.module_enable = 1'b0;
        @(negedge clk);
        check("dis_stanby", bus.STANBY, 0);
        check("dis_coils", coils_now(), 0);
        check("dis_vref", bus.VREF_PWM, 0);
        repeat (4) do_step(1'b0);
        check("dis_idx", bus.phase_idx, 5);
        check("dis_pos", bus.position, m_pos);
        duty("dis_duty", 0);
        bus.module_enable = 1'b1;
        @(negedge clk);
        check("reen_coils", coils_now(), 4'b0101);
        check("reen_stanby", bus.STANBY, 1);
        check("reen_idle", bus.idle, 0);

        // Mode 3 behaves as half step
        bus.step_mode = HALF_ALT;
        bus.direction = 1'b1;
        do_step(1'b0);
        check("mode3_idx", bus.phase_idx, 6);

        // Reset with a step edge inside the synchroniser
        bus.step_pulse = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_coils", coils_now(), 0);
        check("mid_rst_stanby", bus.STANBY, 0);
        check("mid_rst_vref", bus.VREF_PWM, 0);
        check("mid_rst_idx", bus.phase_idx, 0);
        check("mid_rst_pos", bus.position, 0);
        check("mid_rst_ack", bus.step_ack, 0);
        bus.step_pulse = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        m_idx = 3'd0;
        m_pos = '0;
        check("rst_sb_empty", sb_q.size(), 0);
        repeat (8) @(negedge clk);
        check("post_rst_idx", bus.phase_idx, 0);
        check("post_rst_pos", bus.position, 0);
        bus.step_mode = HALF;
        do_step(1'b0);
        check("post_rst_step_idx", bus.phase_idx, 1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
